mem_bist_master: RTL

- Avalon-MM master that runs a March C- memory test against a single-port on-chip RAM slave, for example a Qsys data memory.
- The RAM has a 1-cycle read latency: address is registered in the RAM and the output is unregistered.
- It drives the slave's address, byteenable, chipselect, write, writedata and clken, and checks readdata.
- It sits in the DFT wrapper beside the processor memory and reports pass/fail plus first-failure diagnostics to the test controller.

---
 rtl/mem_bist_pkg.sv | 66 ++++++
 rtl/mem_bist_if.sv | 26 ++
 rtl/mem_bist_addr_gen.sv | 48 ++++
 rtl/mem_bist_master.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared definitions for the March C- memory BIST master.
//   state_t     : FSM states, one per march element (r/w elements split R/W)
//   ELEM_E0..E5 : march element indices
//   ELEM_TABLE  : per-element address direction and data-pattern selects
//   helpers     : state -> element index, bus-cycle classification
package mem_bist_pkg;

    typedef enum logic [3:0] {
        IDLE, E0, E1_R, E1_W, E2_R, E2_W, E3_R, E3_W, E4_R, E4_W, E5, FLUSH, DONE
    } state_t;

    localparam logic [2:0] ELEM_E0 = 3'd0;
    localparam logic [2:0] ELEM_E1 = 3'd1;
    localparam logic [2:0] ELEM_E2 = 3'd2;
    localparam logic [2:0] ELEM_E3 = 3'd3;
    localparam logic [2:0] ELEM_E4 = 3'd4;
    localparam logic [2:0] ELEM_E5 = 3'd5;

    // down   : 1 = descending address order
    // rd_one : expected read value is ~BG (pattern "1") instead of BG
    // wr_one : written value is ~BG instead of BG
    typedef struct packed {
        logic down;
        logic rd_one;
        logic wr_one;
    } elem_cfg_t;

    // Indices 6 and 7 are padding so a 3-bit index never falls off the table.
    localparam elem_cfg_t ELEM_TABLE [0:7] = '{
        '{down: 1'b0, rd_one: 1'b0, wr_one: 1'b0},   // E0 up   w0
        '{down: 1'b0, rd_one: 1'b0, wr_one: 1'b1},   // E1 up   r0 w1
        '{down: 1'b0, rd_one: 1'b1, wr_one: 1'b0},   // E2 up   r1 w0
        '{down: 1'b1, rd_one: 1'b0, wr_one: 1'b1},   // E3 down r0 w1
        '{down: 1'b1, rd_one: 1'b1, wr_one: 1'b0},   // E4 down r1 w0
        '{down: 1'b0, rd_one: 1'b0, wr_one: 1'b0},   // E5 up   r0
        '{down: 1'b0, rd_one: 1'b0, wr_one: 1'b0},
        '{down: 1'b0, rd_one: 1'b0, wr_one: 1'b0}
    };

    function automatic logic [2:0] state_elem(input state_t s);
        logic [2:0] e;
        e = ELEM_E0;
        case (s)
            E1_R, E1_W: e = ELEM_E1;
            E2_R, E2_W: e = ELEM_E2;
            E3_R, E3_W: e = ELEM_E3;
            E4_R, E4_W: e = ELEM_E4;
            E5:         e = ELEM_E5;
            default:    e = ELEM_E0;
        endcase
        return e;
    endfunction

    function automatic logic is_read_state(input state_t s);
        return (s == E1_R) || (s == E2_R) || (s == E3_R) || (s == E4_R) || (s == E5);
    endfunction

    function automatic logic is_write_state(input state_t s);
        return (s == E0) || (s == E1_W) || (s == E2_W) || (s == E3_W) || (s == E4_W);
    endfunction

    function automatic logic is_bus_state(input state_t s);
        return is_read_state(s) || is_write_state(s);
    endfunction

endpackage

// File: rtl/mem_bist_if.sv
// Avalon-MM bus between the BIST master and a single-port RAM slave.
//   master modport drives address/byteenable/chipselect/write/writedata/
//   clken/reset_req and samples readdata; slave modport is the mirror.
interface mem_bist_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                clken;
    logic                reset_req;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, byteenable, chipselect, write, writedata, clken, reset_req,
        input  readdata
    );

    modport slave (
        input  address, byteenable, chipselect, write, writedata, clken, reset_req,
        output readdata
    );
endinterface

// File: rtl/mem_bist_addr_gen.sv
// Up/down address counter for the march sequencer.
//   load/load_down : jump to the first address of an element (0 or DEPTH-1)
//   step/step_down : advance one address in the given direction
//   addr           : current (registered) address
//   addr_next      : value addr takes at the next edge, so the caller can
//                    register bus outputs in step with the counter
//   last_up/last_dn: addr is the final address of an up / down element
module mem_bist_addr_gen
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    input  logic              step_down,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_next,
    output logic              last_up,
    output logic              last_dn
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    always_comb begin
        addr_next = addr;
        if (load) begin
            addr_next = load_down ? LAST_ADDR : '0;
        end else if (step) begin
            addr_next = step_down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
        end else begin
            addr <= addr_next;
        end
    end

    // The sequencer never steps past the end flagged here, so no wrap occurs.
    assign last_up = (addr == LAST_ADDR);
    assign last_dn = (addr == '0);

endmodule

// File: rtl/mem_bist_master.sv
// March C- BIST master for a single-port RAM with 1-cycle read latency.
//   clk, reset   : clock, asynchronous active-high reset
//   start        : 1-cycle request to begin a test (ignored while busy)
//   busy, done   : test in progress / 1-cycle end-of-test pulse
//   fail         : sticky mismatch flag
//   fail_addr    : address of the first mismatch
//   err_count    : saturating mismatch count
//   avm          : Avalon-MM master bus (mem_bist_if.master)
// Optional build macro MEM_BIST_DIAG_EN adds fail_exp / fail_act / fail_elem,
// the expected data, observed data and element index of the first mismatch.
module mem_bist_master
    import mem_bist_pkg::*;
#(
    parameter int                ADDR_W = 12,
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 4096,
    parameter logic [DATA_W-1:0] BG     = '0,
    parameter int                ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ERR_W-1:0]  err_count,
`ifdef MEM_BIST_DIAG_EN
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act,
    output logic [2:0]        fail_elem,
`endif
    mem_bist_if.master        avm
);
    state_t state_reg, state_next;

    logic              ld, ld_down, step, step_down;
    logic [ADDR_W-1:0] addr, addr_next;
    logic              last_up, last_dn, at_last;
    logic [2:0]        cur_elem, next_elem;

    // Registered bus outputs
    logic [ADDR_W-1:0]   address_reg;
    logic [DATA_W/8-1:0] byteenable_reg;
    logic                chipselect_reg, write_reg, clken_reg;
    logic [DATA_W-1:0]   writedata_reg;

    // Read issued last cycle, awaiting its data this cycle
    logic              pend_valid_reg;
    logic [DATA_W-1:0] pend_exp_reg;
    logic [ADDR_W-1:0] pend_addr_reg;
    logic [2:0]        pend_elem_reg;
    logic              mismatch, accept;

    mem_bist_addr_gen #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (ld),
        .load_down (ld_down),
        .step      (step),
        .step_down (step_down),
        .addr      (addr),
        .addr_next (addr_next),
        .last_up   (last_up),
        .last_dn   (last_dn)
    );

    assign cur_elem  = state_elem(state_reg);
    assign next_elem = state_elem(state_next);
    assign step_down = ELEM_TABLE[cur_elem].down;
    assign ld_down   = ELEM_TABLE[next_elem].down;
    assign at_last   = step_down ? last_dn : last_up;
    assign accept    = (state_reg == IDLE) && start;
    assign mismatch  = pend_valid_reg && (avm.readdata != pend_exp_reg);

    // Single-op elements step per cycle; r/w elements step after the W half.
    // The last address of an element loads the next element's first address
    // in the same cycle, so there is no bubble between elements.
    always_comb begin
        state_next = state_reg;
        ld         = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: if (start) begin state_next = E0; ld = 1'b1; end
            E0:   if (at_last) begin state_next = E1_R; ld = 1'b1; end else step = 1'b1;
            E1_R: state_next = E1_W;
            E1_W: if (at_last) begin state_next = E2_R; ld = 1'b1; end
                  else begin state_next = E1_R; step = 1'b1; end
            E2_R: state_next = E2_W;
            E2_W: if (at_last) begin state_next = E3_R; ld = 1'b1; end
                  else begin state_next = E2_R; step = 1'b1; end
            E3_R: state_next = E3_W;
            E3_W: if (at_last) begin state_next = E4_R; ld = 1'b1; end
                  else begin state_next = E3_R; step = 1'b1; end
            E4_R: state_next = E4_W;
            E4_W: if (at_last) begin state_next = E5; ld = 1'b1; end
                  else begin state_next = E4_R; step = 1'b1; end
            E5:   if (at_last) state_next = FLUSH; else step = 1'b1;
            FLUSH: state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state/address and registered,
    // so they line up with state_reg/addr during the cycle they are driven.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            address_reg    <= '0;
            byteenable_reg <= '0;
            chipselect_reg <= 1'b0;
            write_reg      <= 1'b0;
            writedata_reg  <= '0;
            clken_reg      <= 1'b1;
            pend_valid_reg <= 1'b0;
            pend_exp_reg   <= '0;
            pend_addr_reg  <= '0;
            pend_elem_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            busy           <= (state_next != IDLE) && (state_next != DONE);
            done           <= (state_next == DONE);
            clken_reg      <= 1'b1;
            chipselect_reg <= is_bus_state(state_next);
            write_reg      <= is_write_state(state_next);
            byteenable_reg <= is_bus_state(state_next) ? '1 : '0;
            address_reg    <= is_bus_state(state_next) ? addr_next : '0;
            writedata_reg  <= is_write_state(state_next)
                              ? (ELEM_TABLE[next_elem].wr_one ? ~BG : BG) : '0;
            // Tag the read being driven now; its data is checked next cycle.
            pend_valid_reg <= is_read_state(state_reg);
            pend_exp_reg   <= ELEM_TABLE[cur_elem].rd_one ? ~BG : BG;
            pend_addr_reg  <= addr;
            pend_elem_reg  <= cur_elem;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            err_count <= '0;
`ifdef MEM_BIST_DIAG_EN
            fail_exp  <= '0;
            fail_act  <= '0;
            fail_elem <= '0;
`endif
        end else if (accept) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            err_count <= '0;
`ifdef MEM_BIST_DIAG_EN
            fail_exp  <= '0;
            fail_act  <= '0;
            fail_elem <= '0;
`endif
        end else if (mismatch) begin
            fail <= 1'b1;
            if (!fail) begin
                fail_addr <= pend_addr_reg;
`ifdef MEM_BIST_DIAG_EN
                fail_exp  <= pend_exp_reg;
                fail_act  <= avm.readdata;
                fail_elem <= pend_elem_reg;
`endif
            end
            if (err_count != {ERR_W{1'b1}}) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

    assign avm.address    = address_reg;
    assign avm.byteenable = byteenable_reg;
    assign avm.chipselect = chipselect_reg;
    assign avm.write      = write_reg;
    assign avm.writedata  = writedata_reg;
    assign avm.clken      = clken_reg;
    assign avm.reset_req  = 1'b0;

endmodule
